// File: rtl/ripple_mod_counter.sv
// ripple_mod_counter
//   Modulo-MODULUS up/down counter with a programmable step. The next-state
//   arithmetic uses ripple-carry chains of 1-bit full-adder cells; wrap or
//   saturate on crossing the range limit, with terminal-count, wrap-pulse and
//   sticky-overflow status.
//
// Parameters
//   WIDTH    : counter and step width in bits (>= 2)
//   MODULUS  : count range 0..MODULUS-1, 2 <= MODULUS <= 2**WIDTH
//   SATURATE : 0 = wrap modulo MODULUS, 1 = hold at the limit
//
// Ports
//   clk      : rising-edge clock
//   rst      : asynchronous active-high reset (count, wrap, ovf -> 0)
//   clr      : synchronous clear (count, wrap, ovf -> 0)
//   load     : synchronous load of load_val (clamped to MODULUS-1)
//   load_val : value to load
//   en       : count enable
//   up       : 1 = count up, 0 = count down
//   step     : increment/decrement amount (clamped to MODULUS-1)
//   count    : current count (registered)
//   tc       : terminal count, combinational from count and up
//   wrap     : registered one-cycle pulse on a wrap/saturate event
//   ovf      : sticky overflow flag, cleared only by rst or clr
module ripple_mod_counter #(
    parameter int WIDTH    = 8,
    parameter int MODULUS  = 256,
    parameter int SATURATE = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    input  logic             up,
    input  logic [WIDTH-1:0] step,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             wrap,
    output logic             ovf
);

    localparam logic [WIDTH:0]   MOD_X      = (WIDTH+1)'(MODULUS);
    localparam logic [WIDTH-1:0] MOD_LO     = WIDTH'(MODULUS);
    localparam logic [WIDTH-1:0] MAXV       = WIDTH'(MODULUS - 1);
    localparam bit               FULL_RANGE = (MODULUS == (1 << WIDTH));

    // WIDTH+1-bit ripple chain of full-adder cells
    function automatic logic [WIDTH:0] rca_x(input logic [WIDTH:0] a,
                                             input logic [WIDTH:0] b,
                                             input logic           cin);
        logic [WIDTH:0] c;
        logic [WIDTH:0] s;
        c[0] = cin;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            s[i]   = a[i] ^ b[i] ^ c[i];
            c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
        s[WIDTH] = a[WIDTH] ^ b[WIDTH] ^ c[WIDTH];
        return s;
    endfunction

    // WIDTH-bit ripple chain, result taken modulo 2**WIDTH
    function automatic logic [WIDTH-1:0] rca_w(input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b,
                                               input logic             cin);
        logic [WIDTH-1:0] c;
        logic [WIDTH-1:0] s;
        c[0] = cin;
        for (int unsigned i = 0; i < WIDTH - 1; i++) begin
            s[i]   = a[i] ^ b[i] ^ c[i];
            c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
        s[WIDTH-1] = a[WIDTH-1] ^ b[WIDTH-1] ^ c[WIDTH-1];
        return s;
    endfunction

    logic [WIDTH-1:0] count_q, count_d;
    logic             wrap_q, wrap_d;
    logic             ovf_q, ovf_d;

    logic [WIDTH-1:0] s_eff;
    logic [WIDTH-1:0] ld_val;
    logic [WIDTH:0]   add_res;
    logic             up_lim;
    logic             dn_borrow;
    logic [WIDTH-1:0] up_wrapv;
    logic [WIDTH-1:0] dn_wrapv;

    always_comb begin
        s_eff  = ({1'b0, step} < MOD_X) ? step : MAXV;
        ld_val = ({1'b0, load_val} < MOD_X) ? load_val : MAXV;

        // Up: count + s. Down: count + ~s + 1, so bit WIDTH is the
        // carry-out of the WIDTH-bit part and 0 signals a borrow.
        add_res   = rca_x({1'b0, count_q}, {1'b0, (up ? s_eff : ~s_eff)}, ~up);
        up_lim    = FULL_RANGE ? add_res[WIDTH] : (add_res >= MOD_X);
        dn_borrow = ~add_res[WIDTH];

        // Wrapped results: sum - MODULUS for up, (count - s) + MODULUS for
        // down; both land in 0..MODULUS-1, so WIDTH-bit arithmetic suffices.
        up_wrapv = rca_w(add_res[WIDTH-1:0], ~MOD_LO, 1'b1);
        dn_wrapv = rca_w(add_res[WIDTH-1:0], MOD_LO, 1'b0);

        count_d = count_q;
        wrap_d  = 1'b0;
        ovf_d   = ovf_q;

        if (clr) begin
            count_d = '0;
            ovf_d   = 1'b0;
        end else if (load) begin
            count_d = ld_val;
        end else if (en) begin
            if (up) begin
                if (up_lim) begin
                    count_d = (SATURATE != 0) ? MAXV : up_wrapv;
                    wrap_d  = 1'b1;
                    ovf_d   = 1'b1;
                end else begin
                    count_d = add_res[WIDTH-1:0];
                end
            end else begin
                if (dn_borrow) begin
                    count_d = (SATURATE != 0) ? '0 : dn_wrapv;
                    wrap_d  = 1'b1;
                    ovf_d   = 1'b1;
                end else begin
                    count_d = add_res[WIDTH-1:0];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
            wrap_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            wrap_q  <= wrap_d;
            ovf_q   <= ovf_d;
        end
    end

    assign count = count_q;
    assign wrap  = wrap_q;
    assign ovf   = ovf_q;
    assign tc    = up ? (count_q == MAXV) : (count_q == '0);

endmodule

// File: tb/tb_ripple_mod_counter.sv
// Testbench for ripple_mod_counter. Three instances share one stimulus:
//   u0: WIDTH=4 MODULUS=10 SATURATE=0
//   u1: WIDTH=4 MODULUS=10 SATURATE=1
//   u2: WIDTH=4 MODULUS=16 SATURATE=0
// Expected outputs come from an integer-arithmetic model and are queued per
// clock edge; a monitor pops and compares after each rising edge.
module tb_ripple_mod_counter;

    logic       clk = 1'b0;
    logic       rst, clr, load, en, up;
    logic [3:0] load_val, step;

    logic [3:0] c0, c1, c2;
    logic       t0, t1, t2, w0, w1, w2, o0, o1, o2;

    ripple_mod_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(0)) u0 (
        .clk(clk), .rst(rst), .clr(clr), .load(load), .load_val(load_val),
        .en(en), .up(up), .step(step), .count(c0), .tc(t0), .wrap(w0), .ovf(o0));
    ripple_mod_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1)) u1 (
        .clk(clk), .rst(rst), .clr(clr), .load(load), .load_val(load_val),
        .en(en), .up(up), .step(step), .count(c1), .tc(t1), .wrap(w1), .ovf(o1));
    ripple_mod_counter #(.WIDTH(4), .MODULUS(16), .SATURATE(0)) u2 (
        .clk(clk), .rst(rst), .clr(clr), .load(load), .load_val(load_val),
        .en(en), .up(up), .step(step), .count(c2), .tc(t2), .wrap(w2), .ovf(o2));

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0][3:0] cnt;
        logic [2:0]      wr;
        logic [2:0]      ov;
        logic [2:0]      tc;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;

    // Reference model state, one entry per instance
    int mc[3];
    int mw[3];
    int mo[3];

    function automatic int mod_of(input int i);
        return (i == 2) ? 16 : 10;
    endfunction

    function automatic int sat_of(input int i);
        return (i == 1) ? 1 : 0;
    endfunction

    function automatic int act_cnt(input int i);
        return (i == 0) ? int'(c0) : (i == 1) ? int'(c1) : int'(c2);
    endfunction
    function automatic int act_wr(input int i);
        return (i == 0) ? int'(w0) : (i == 1) ? int'(w1) : int'(w2);
    endfunction
    function automatic int act_ov(input int i);
        return (i == 0) ? int'(o0) : (i == 1) ? int'(o1) : int'(o2);
    endfunction
    function automatic int act_tc(input int i);
        return (i == 0) ? int'(t0) : (i == 1) ? int'(t1) : int'(t2);
    endfunction

    task automatic chk(input string nm, input int idx, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s u%0d at %0t: got=%0d want=%0d", nm, idx, $time, act, exp);
        end
    endtask

    // One clock edge of the specified behaviour, in plain integers
    task automatic model_step(input int i);
        int m, s, lv, st;
        m  = mod_of(i);
        lv = int'(load_val);
        st = int'(step);
        if (rst || clr) begin
            mc[i] = 0; mw[i] = 0; mo[i] = 0;
        end else if (load) begin
            mc[i] = (lv < m) ? lv : m - 1;
            mw[i] = 0;
        end else if (en) begin
            s = (st < m) ? st : m - 1;
            if (up) begin
                if (mc[i] + s >= m) begin
                    mc[i] = sat_of(i) ? m - 1 : mc[i] + s - m;
                    mw[i] = 1; mo[i] = 1;
                end else begin
                    mc[i] = mc[i] + s;
                    mw[i] = 0;
                end
            end else begin
                if (mc[i] >= s) begin
                    mc[i] = mc[i] - s;
                    mw[i] = 0;
                end else begin
                    mc[i] = sat_of(i) ? 0 : mc[i] + m - s;
                    mw[i] = 1; mo[i] = 1;
                end
            end
        end else begin
            mw[i] = 0;
        end
    endtask

    // Apply current inputs for one edge; called at the falling edge
    task automatic cycle();
        exp_t e;
        for (int i = 0; i < 3; i++) begin
            model_step(i);
            e.cnt[i] = 4'(mc[i]);
            e.wr[i]  = (mw[i] != 0);
            e.ov[i]  = (mo[i] != 0);
            e.tc[i]  = up ? (mc[i] == mod_of(i) - 1) : (mc[i] == 0);
        end
        q.push_back(e);
        @(posedge clk);
        @(negedge clk);
    endtask

    // Monitor: compare each edge's outputs against the queued expectation
    exp_t me;
    always @(posedge clk) begin
        #1;
        if (q.size() != 0) begin
            me = q.pop_front();
            for (int i = 0; i < 3; i++) begin
                chk("count", i, act_cnt(i), int'(me.cnt[i]));
                chk("wrap",  i, act_wr(i),  int'(me.wr[i]));
                chk("ovf",   i, act_ov(i),  int'(me.ov[i]));
                chk("tc",    i, act_tc(i),  int'(me.tc[i]));
            end
        end
    end

    initial begin
        rst = 1'b1; clr = 1'b0; load = 1'b0; en = 1'b0; up = 1'b1;
        load_val = '0; step = '0;
        for (int i = 0; i < 3; i++) begin mc[i] = 0; mw[i] = 0; mo[i] = 0; end
        cycle();
        cycle();
        rst = 1'b0;

        // Count up by 1 through a wrap of modulus 10
        en = 1'b1; up = 1'b1; step = 4'd1;
        repeat (12) cycle();
        chk("dir_up_cnt", 0, int'(c0), 2);
        chk("dir_up_ovf", 0, int'(o0), 1);

        // Load 3 then count down by 4: 9, 5, 1, 7
        en = 1'b0; load = 1'b1; load_val = 4'd3;
        cycle();
        load = 1'b0; en = 1'b1; up = 1'b0; step = 4'd4;
        repeat (4) cycle();
        chk("dir_dn_cnt", 0, int'(c0), 7);
        chk("dir_dn_wrap", 0, int'(w0), 1);

        // Saturate: load 8, step up 3 twice, then a clamped step down
        en = 1'b0; load = 1'b1; load_val = 4'd8;
        cycle();
        load = 1'b0; en = 1'b1; up = 1'b1; step = 4'd3;
        repeat (2) cycle();
        chk("dir_sat_cnt", 1, int'(c1), 9);
        chk("dir_sat_wrap", 1, int'(w1), 1);
        up = 1'b0; step = 4'd15;
        cycle();
        chk("dir_sat_dn", 1, int'(c1), 0);

        // Out-of-range load with en also high, then clear
        load = 1'b1; load_val = 4'd12; en = 1'b1; step = 4'd5;
        cycle();
        chk("dir_ld_clamp", 0, int'(c0), 9);
        chk("dir_ld_wrap", 0, int'(w0), 0);
        load = 1'b0; en = 1'b0; clr = 1'b1;
        cycle();
        clr = 1'b0;
        chk("dir_clr_ovf", 0, int'(o0), 0);

        // Full-range modulus wrap through the carry-out
        load = 1'b1; load_val = 4'd15;
        cycle();
        load = 1'b0; en = 1'b1; up = 1'b1; step = 4'd1;
        cycle();
        chk("dir_full_cnt", 2, int'(c2), 0);
        chk("dir_full_wrap", 2, int'(w2), 1);

        // Asynchronous reset between edges
        repeat (3) cycle();
        rst = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("async_cnt", i, act_cnt(i), 0);
            chk("async_ovf", i, act_ov(i), 0);
            chk("async_wrap", i, act_wr(i), 0);
        end
        cycle();
        rst = 1'b0;

        // Randomised traffic
        for (int n = 0; n < 10000; n++) begin
            rst      = ($urandom_range(0, 199) == 0);
            clr      = ($urandom_range(0, 49) == 0);
            load     = ($urandom_range(0, 19) == 0);
            en       = ($urandom_range(0, 9) < 8);
            up       = $urandom_range(0, 1) != 0;
            load_val = 4'($urandom_range(0, 15));
            step     = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15))
                                                   : 4'($urandom_range(0, 3));
            cycle();
        end
        rst = 1'b0; clr = 1'b0; load = 1'b0; en = 1'b0;

        for (int k = 0; k < 5 && q.size() != 0; k++) begin
            @(posedge clk);
            #2;
        end
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain: got=%0d pending want=0", q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
